prog_loader: RTL and testbench

//  Front-end stage feeding the core's instruction fetch. Accepts a program as a stream of 9-bit

---
 rtl/loader_pkg.sv | 14 +
 rtl/instr_ram.sv | 20 ++
 rtl/prog_loader.sv | 109 ++++++++++
 tb/tb_prog_loader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and default sizes for the program loader.
package loader_pkg;
  localparam int          DW        = 9;
  localparam int          AW        = 6;
  localparam int          RST_CYC   = 2;
  localparam logic [DW-1:0] HALT_CODE = 9'h1FF;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_HALT    = 2'd3
  } state_e;
endpackage

// File: rtl/instr_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port, no reset.
module instr_ram #(
  parameter int DW = 9,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/prog_loader.sv
// Streams a program into the instruction RAM, sequences core reset, serves fetches and
// halts the core on Done.
module prog_loader
  import loader_pkg::*;
#(
  parameter int            DW        = loader_pkg::DW,
  parameter int            AW        = loader_pkg::AW,
  parameter int            RST_CYC   = loader_pkg::RST_CYC,
  parameter logic [DW-1:0] HALT_CODE = loader_pkg::HALT_CODE
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          LdValid,
  input  logic [DW-1:0] LdData,
  input  logic          LdLast,
  output logic          LdReady,
  input  logic          Restart,
  input  logic [AW-1:0] PC,
  output logic [DW-1:0] mach_code,
  input  logic          CoreDone,
  output logic          CoreReset,
  output logic          Finished,
  output logic [AW:0]   LoadCount,
  output logic          Overflow
);
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
  localparam logic [3:0]    RCNT_INIT = 4'(RST_CYC - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    rcnt_q, rcnt_d;
  logic          we;
  logic [DW-1:0] ram_rdata;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_LOAD;
      wptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    rcnt_d  = rcnt_q;
    we      = 1'b0;
    // Restart outranks everything, including a word offered in the same cycle.
    if (Restart) begin
      state_d = ST_LOAD;
      wptr_d  = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (LdValid) begin
            we     = 1'b1;
            wptr_d = wptr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (LdLast || wptr_q == LAST_ADDR) begin
              state_d = ST_RELEASE;
              rcnt_d  = RCNT_INIT;
              if (!LdLast) ovf_d = 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          if (rcnt_q == '0) state_d = ST_RUN;
          else              rcnt_d  = rcnt_q - 1'b1;
        end
        ST_RUN: begin
          if (CoreDone) state_d = ST_HALT;
        end
        default: ;
      endcase
    end
  end

  instr_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (Clk),
    .we    (we),
    .waddr (wptr_q),
    .wdata (LdData),
    .raddr (PC),
    .rdata (ram_rdata)
  );

  // Stale RAM beyond the loaded length must never reach the core.
  assign mach_code = (state_q == ST_RUN && {1'b0, PC} < cnt_q) ? ram_rdata : HALT_CODE;
  assign LdReady   = (state_q == ST_LOAD);
  assign CoreReset = (state_q != ST_RUN);
  assign Finished  = (state_q == ST_HALT);
  assign LoadCount = cnt_q;
  assign Overflow  = ovf_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with hand-computed expectations.
module tb_prog_loader;
  logic       Clk = 1'b0;
  logic       Reset;
  logic       LdValid;
  logic [8:0] LdData;
  logic       LdLast;
  logic       LdReady;
  logic       Restart;
  logic [5:0] PC;
  logic [8:0] mach_code;
  logic       CoreDone;
  logic       CoreReset;
  logic       Finished;
  logic [6:0] LoadCount;
  logic       Overflow;

  int n_vec = 0;
  int n_err = 0;

  prog_loader dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .LdValid   (LdValid),
    .LdData    (LdData),
    .LdLast    (LdLast),
    .LdReady   (LdReady),
    .Restart   (Restart),
    .PC        (PC),
    .mach_code (mach_code),
    .CoreDone  (CoreDone),
    .CoreReset (CoreReset),
    .Finished  (Finished),
    .LoadCount (LoadCount),
    .Overflow  (Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [8:0] d, input logic last);
    LdValid = 1'b1;
    LdData  = d;
    LdLast  = last;
    tick();
    LdValid = 1'b0;
    LdLast  = 1'b0;
  endtask

  task automatic pc_check(input string tag, input logic [5:0] pc, input logic [8:0] exp);
    PC = pc;
    #1;
    check(tag, 16'(mach_code), 16'(exp));
  endtask

  task automatic do_restart();
    Restart = 1'b1;
    tick();
    Restart = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; LdValid = 1'b0; LdData = '0; LdLast = 1'b0;
    Restart = 1'b0; PC = '0; CoreDone = 1'b0;
    #13;
    check("rst_ldready",   16'(LdReady),   16'd1);
    check("rst_corereset", 16'(CoreReset), 16'd1);
    check("rst_finished",  16'(Finished),  16'd0);
    check("rst_mach_code", 16'(mach_code), 16'h1FF);
    check("rst_loadcount", 16'(LoadCount), 16'd0);
    check("rst_overflow",  16'(Overflow),  16'd0);
    Reset = 1'b0;
    tick();

    // Three back-to-back words.
    send(9'h011, 1'b0);
    send(9'h022, 1'b0);
    send(9'h033, 1'b1);
    check("t1_loadcount", 16'(LoadCount), 16'd3);
    check("t1_ldready",   16'(LdReady),   16'd0);
    check("t1_crst_c1",   16'(CoreReset), 16'd1);
    pc_check("t1_release_gate", 6'd0, 9'h1FF);
    tick();
    check("t1_crst_c2",   16'(CoreReset), 16'd1);
    tick();
    check("t1_crst_run",  16'(CoreReset), 16'd0);
    pc_check("t1_pc0", 6'd0, 9'h011);
    pc_check("t1_pc1", 6'd1, 9'h022);
    pc_check("t1_pc2", 6'd2, 9'h033);
    pc_check("t1_pc3", 6'd3, 9'h1FF);

    // Done -> HALT, then Restart back to LOAD.
    CoreDone = 1'b1;
    tick();
    CoreDone = 1'b0;
    check("halt_finished",  16'(Finished),  16'd1);
    check("halt_corereset", 16'(CoreReset), 16'd1);
    check("halt_ldready",   16'(LdReady),   16'd0);
    pc_check("halt_gate", 6'd0, 9'h1FF);
    tick();
    check("halt_stays", 16'(Finished), 16'd1);
    do_restart();
    check("rs_ldready",   16'(LdReady),   16'd1);
    check("rs_finished",  16'(Finished),  16'd0);
    check("rs_loadcount", 16'(LoadCount), 16'd0);
    check("rs_overflow",  16'(Overflow),  16'd0);

    // Gaps between words; data presented while LdValid=0 must be ignored.
    send(9'h101, 1'b0);
    check("gap_cnt1", 16'(LoadCount), 16'd1);
    LdData = 9'h0EE; LdLast = 1'b1;
    tick(); tick();
    LdLast = 1'b0;
    check("gap_cnt_hold", 16'(LoadCount), 16'd1);
    check("gap_still_load", 16'(LdReady), 16'd1);
    send(9'h102, 1'b0);
    send(9'h103, 1'b0);
    check("gap_cnt3", 16'(LoadCount), 16'd3);
    tick();
    send(9'h104, 1'b1);
    check("gap_cnt4", 16'(LoadCount), 16'd4);
    tick(); tick();
    pc_check("gap_pc0", 6'd0, 9'h101);
    pc_check("gap_pc1", 6'd1, 9'h102);
    pc_check("gap_pc2", 6'd2, 9'h103);
    pc_check("gap_pc3", 6'd3, 9'h104);
    pc_check("gap_pc4", 6'd4, 9'h1FF);

    // Restart beats CoreDone in RUN.
    Restart = 1'b1; CoreDone = 1'b1;
    tick();
    Restart = 1'b0; CoreDone = 1'b0;
    check("rsdone_ldready",  16'(LdReady),  16'd1);
    check("rsdone_finished", 16'(Finished), 16'd0);

    // Restart beats a transfer in LOAD.
    Restart = 1'b1; LdValid = 1'b1; LdData = 9'h0AA; LdLast = 1'b1;
    #1;
    check("rsld_ready_same_cycle", 16'(LdReady), 16'd1);
    tick();
    Restart = 1'b0; LdValid = 1'b0; LdLast = 1'b0;
    check("rsld_loadcount", 16'(LoadCount), 16'd0);
    check("rsld_ldready",   16'(LdReady),   16'd1);

    // 64 words without LdLast -> overflow.
    for (int i = 0; i < 64; i++) begin
      send({3'b101, 6'(i)}, 1'b0);
      if (i == 62) begin
        check("ovf_cnt63", 16'(LoadCount), 16'd63);
        check("ovf_not_yet", 16'(Overflow), 16'd0);
      end
    end
    check("ovf_flag",      16'(Overflow),  16'd1);
    check("ovf_loadcount", 16'(LoadCount), 16'd64);
    check("ovf_ldready",   16'(LdReady),   16'd0);
    check("ovf_corereset", 16'(CoreReset), 16'd1);
    tick(); tick();
    check("ovf_run", 16'(CoreReset), 16'd0);
    pc_check("ovf_pc63", 6'd63, 9'h17F);
    pc_check("ovf_pc0",  6'd0,  9'h140);
    check("ovf_sticky", 16'(Overflow), 16'd1);

    // Async reset mid-load.
    do_restart();
    for (int i = 0; i < 5; i++) send(9'h050 + 9'(i), 1'b0);
    check("ar_cnt5", 16'(LoadCount), 16'd5);
    #2;
    Reset = 1'b1;
    #1;
    check("ar_loadcount", 16'(LoadCount), 16'd0);
    check("ar_ldready",   16'(LdReady),   16'd1);
    check("ar_corereset", 16'(CoreReset), 16'd1);
    check("ar_mach_code", 16'(mach_code), 16'h1FF);
    Reset = 1'b0;
    tick();
    send(9'h123, 1'b1);
    tick(); tick();
    pc_check("ar_pc0",  6'd0,  9'h123);
    pc_check("ar_pc1",  6'd1,  9'h1FF);
    pc_check("ar_pc4",  6'd4,  9'h1FF);
    pc_check("ar_pc63", 6'd63, 9'h1FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
